ahb_pixel_slave: RTL
====================

Name: ahb_pixel_slave

Overview:
AHB-Lite slave at the receiving end of the Sobel master's bus transfers; it is selected by the ahbSlaveDecoder HSEL line. Word writes deliver pixels into an internal FIFO, which streams them to the convolution engine over a valid/ready interface. The slave captures edge-detected results from the convolution engine and exposes control, status and result registers. When the FIFO is full, the slave inserts AHB wait states.

Parameters:
FIFO_DEPTH, 16, pixel FIFO entries; must be a power of two, at least 4.
CNT_W, $clog2(FIFO_DEPTH)+1, FIFO occupancy counter width.

Ports:
HCLK  input  1  bus clock; the block's single clock
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  slave select from decoder
HADDR  input  32  address; only [3:0] decoded
HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HWRITE  input  1  1 = write
HSIZE  input  3  only 3'b010 (word) is legal
HWDATA  input  32  write data, valid in data phase
HREADY  input  1  bus-level ready; qualifies the address phase
HRDATA  output  32  read data
HREADYOUT  output  1  slave ready
HRESP  output  1  0 = OKAY, 1 = ERROR
pix_data  output  8  pixel to the convolution engine
pix_valid  output  1  pixel available
pix_ready  input  1  convolution engine accepts the pixel
edge_pixel  input  8  convolution result
edge_valid  input  1  result strobe, one cycle
fifo_full  output  1  FIFO full flag, for the top level

Behaviour:
Reset, asynchronous on HRESETn low:
- FIFO emptied.
- All registers cleared.
- HRDATA=0, HREADYOUT=1, HRESP=0, pix_valid=0, fifo_full=0.
- Mid-transfer reset abandons the transfer.

Address phase:
- Accepted when HSEL & HTRANS[1] & HREADY.
- On acceptance, register HADDR[3:0], HWRITE and HSIZE, and set dphase=1.
- If not accepted while HREADY=1, set dphase=0.
- IDLE and BUSY transfers get a zero-wait OKAY response.

Register map (word offsets):
- 0x0 CTRL, R/W.
  - bit0 enable.
  - bit1 clear: write-1 pulse; reads 0.
- 0x4 STATUS, read-only.
  - bit0 full, bit1 empty, bit2 result_valid, bit3 overflow.
  - bits[8+:CNT_W] count.
- 0x8 PIXEL, write-only. HWDATA[7:0] is pushed into the FIFO; upper bits are ignored.
- 0xC RESULT, read-only. Returns {24'b0, result}; the read clears result_valid.

Error response, always two cycles:
- Triggers:
  - HSIZE != 3'b010.
  - HADDR[1:0] != 0.
  - Write to STATUS or RESULT.
  - Read of PIXEL.
- Cycle 1: HRESP=1, HREADYOUT=0.
- Cycle 2: HRESP=1, HREADYOUT=1.
- No state change.

Control state machine:
- States: IDLE, DATA, WAIT, ERR1, ERR2.
- A PIXEL write in its data phase completes (HREADYOUT=1) when !full, or when full and a pop happens in the same cycle. Push and pop in the same cycle leave count unchanged.
- Otherwise the FSM goes to WAIT with HREADYOUT=0 and HWDATA held by the master; there is no timeout.
- The push occurs in the cycle HREADYOUT=1.
- Reads are zero-wait. HRDATA is driven combinationally from the registered address during the data phase, and is 0 otherwise.
- STATUS reads return the pre-update value of the current cycle.

Stream side:
- pix_valid = enable & !empty; pix_data = FIFO head.
- Pop when pix_valid & pix_ready. Clearing enable freezes the stream but not bus pushes.

Results:
- edge_valid loads result and sets result_valid.
- If result_valid is already 1, overflow is also set and the new value overwrites.
- edge_valid in the same cycle as a RESULT read: the read returns the old value, and result_valid stays 1 (set wins).

Clear (data-phase write with bit1=1):
- Empties the FIFO and zeroes result, result_valid and overflow.
- Clear wins over a simultaneous pop or edge_valid.
- enable takes bit0 of the same write.

Timing:
- fifo_full is a register equal to count==FIFO_DEPTH.
- HREADYOUT may depend combinationally on pix_ready.

Decomposition:
- Package ahb_pkg:
  - HTRANS codes and HRESP codes.
  - Register offsets (CTRL=4'h0, STATUS=4'h4, PIXEL=4'h8, RESULT=4'hC).
  - STATUS bit positions.
  - Slave FSM state enum.
- Sub-module pixel_fifo:
  - Synchronous FIFO, parameterised on DEPTH and WIDTH=8.
  - Ports: push, pop, clear, din, dout, full, empty, count.
  - Wrap-around pointers with an extra MSB.

Test Plan:
1. Reset, then write CTRL=0x1 and PIXEL=0xA5, with pix_ready=1 -> pix_valid rises the cycle after the write data phase, pix_data=0xA5; STATUS reads empty=1, count=0.
2. pix_ready=0, 17 back-to-back PIXEL writes with values 0..16, FIFO_DEPTH=16 -> the 17th data phase holds HREADYOUT=0 and fifo_full=1. Then set pix_ready=1 for one cycle -> 0x00 pops, the 17th completes the same cycle, and count stays 16.
3. Read STATUS at offset 0x6 (unaligned), write STATUS, read PIXEL, HSIZE=byte -> each gets a two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1) and registers are unchanged.
4. edge_valid with 0x3C, then 0x7E with no read in between -> RESULT reads 0x7E, STATUS shows overflow=1, and result_valid=0 after the read.
5. edge_valid=0x11 in the same cycle as a RESULT read holding 0x22 -> HRDATA=0x22 and result_valid remains 1. The next RESULT read returns 0x11.
6. FIFO holding 5 pixels, then CTRL write 0x3 -> empty=1 and overflow=0 next cycle; asserting HRESETn low mid WAIT state -> HREADYOUT=1 immediately and FIFO empty.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite codes, register map and slave state encoding for the pixel slave.
package ahb_pkg;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    localparam logic HrespOkay  = 1'b0;
    localparam logic HrespError = 1'b1;

    localparam logic [2:0] HsizeWord = 3'b010;

    localparam logic [3:0] AddrCtrl   = 4'h0;
    localparam logic [3:0] AddrStatus = 4'h4;
    localparam logic [3:0] AddrPixel  = 4'h8;
    localparam logic [3:0] AddrResult = 4'hC;

    localparam int unsigned CtrlEnable = 0;
    localparam int unsigned CtrlClear  = 1;

    localparam int unsigned StatFull   = 0;
    localparam int unsigned StatEmpty  = 1;
    localparam int unsigned StatRvalid = 2;
    localparam int unsigned StatOvf    = 3;
    localparam int unsigned StatCount  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StWait,
        StErr1,
        StErr2
    } slave_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO; pointers carry an extra wrap bit so full and empty are distinct.
module pixel_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             full_q;
    logic             do_push, do_pop;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = full_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop & ~empty & ~clear;
    // A full FIFO still accepts a push when a pop frees the head slot this cycle.
    assign do_push = push & (~full_q | do_pop) & ~clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= ((wr_ptr_d - rd_ptr_d) == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ahb_pixel_slave.sv
// AHB-Lite slave: pixel writes feed a FIFO streamed to the convolution engine,
// edge results are captured into a readable result register.
module ahb_pixel_slave
    import ahb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    input  logic [7:0]  edge_pixel,
    input  logic        edge_valid,
    output logic        fifo_full
);

    slave_state_e st_q, st_d, addr_next;
    logic [3:0]   addr_q;
    logic         write_q;
    logic         enable_q;
    logic [7:0]   result_q;
    logic         result_valid_q;
    logic         overflow_q;

    logic             accept, addr_err;
    logic             data_phase, rd_phase, pixel_wr, ctrl_wr, result_rd;
    logic             clear, pop, push, can_push;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      status_word;
    logic             unused_bits;

    assign unused_bits = ^{HADDR[31:4], HTRANS[0], HWDATA[31:8]};

    assign accept   = HSEL & HTRANS[1] & HREADY;
    assign addr_err = (HSIZE != HsizeWord) || (HADDR[1:0] != 2'b00) ||
                      (HWRITE && ((HADDR[3:0] == AddrStatus) || (HADDR[3:0] == AddrResult))) ||
                      (!HWRITE && (HADDR[3:0] == AddrPixel));

    assign data_phase = (st_q == StData) || (st_q == StWait);
    assign rd_phase   = (st_q == StData) && !write_q;
    assign pixel_wr   = data_phase && write_q && (addr_q == AddrPixel);
    assign ctrl_wr    = (st_q == StData) && write_q && (addr_q == AddrCtrl);
    assign result_rd  = rd_phase && (addr_q == AddrResult);
    assign clear      = ctrl_wr && HWDATA[CtrlClear];

    assign pix_valid = enable_q & ~fifo_empty;
    assign pop       = pix_valid & pix_ready & ~clear;
    assign can_push  = ~fifo_full | pop;
    assign push      = pixel_wr & can_push;

    always_comb begin
        addr_next = accept ? (addr_err ? StErr1 : StData) : StIdle;
        st_d      = st_q;
        HREADYOUT = 1'b1;
        HRESP     = HrespOkay;
        case (st_q)
            StIdle: st_d = addr_next;
            StData, StWait: begin
                if (pixel_wr && !can_push) begin
                    HREADYOUT = 1'b0;
                    st_d      = StWait;
                end else begin
                    st_d = addr_next;
                end
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = HrespError;
                st_d      = StErr2;
            end
            StErr2: begin
                HRESP = HrespError;
                st_d  = addr_next;
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            st_q    <= StIdle;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            st_q <= st_d;
            if (accept) begin
                addr_q  <= HADDR[3:0];
                write_q <= HWRITE;
            end
        end
    end

    // Clear beats a same-cycle edge strobe; an edge strobe beats a same-cycle result read.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            enable_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            if (ctrl_wr) enable_q <= HWDATA[CtrlEnable];
            if (clear) begin
                result_q       <= '0;
                result_valid_q <= 1'b0;
                overflow_q     <= 1'b0;
            end else if (edge_valid) begin
                result_q       <= edge_pixel;
                result_valid_q <= 1'b1;
                if (result_valid_q) overflow_q <= 1'b1;
            end else if (result_rd) begin
                result_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        status_word                      = '0;
        status_word[StatFull]            = fifo_full;
        status_word[StatEmpty]           = fifo_empty;
        status_word[StatRvalid]          = result_valid_q;
        status_word[StatOvf]             = overflow_q;
        status_word[StatCount +: CNT_W]  = fifo_count;
        HRDATA = '0;
        if (rd_phase) begin
            case (addr_q)
                AddrCtrl:   HRDATA[CtrlEnable] = enable_q;
                AddrStatus: HRDATA = status_word;
                AddrResult: HRDATA = {24'b0, result_q};
                default:    HRDATA = '0;
            endcase
        end
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (HWDATA[7:0]),
        .dout  (pix_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
